decode_stage: RTL

- Instruction decode stage directly downstream of the fetch stage.
- Accepts raw 32-bit RV32I instructions over a valid/ready handshake and tracks the PC of every accepted instruction.
- Classifies each instruction, extracts register indices, generates sign-extended immediates, flags illegal encodings, and holds the result in one output pipeline register for the execute stage.
- Drives register-file read addresses combinationally so read data lines up with the registered decode output.

---
 rtl/decode_stage.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: accepts raw instructions from fetch over valid/ready,
// tracks the PC of every accepted instruction, and registers a decoded bundle
// (class, register indices, immediate, write enable, illegal flag) for execute.
module decode_stage #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter bit          SUPPORT_FENCE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] start_addr_i,
  input  logic        flush_i,
  input  logic [31:0] flush_addr_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_instr_i,
  output logic [4:0]  rf_rs1_addr_o,
  output logic [4:0]  rf_rs2_addr_o,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instr_o,
  output logic [3:0]  id_op_o,
  output logic [4:0]  id_rd_o,
  output logic [4:0]  id_rs1_o,
  output logic [4:0]  id_rs2_o,
  output logic [2:0]  id_funct3_o,
  output logic        id_f7b5_o,
  output logic [31:0] id_imm_o,
  output logic        id_we_o,
  output logic        id_illegal_o
);

  typedef enum logic [3:0] {
    OP_NONE   = 4'd0,  OP_LUI    = 4'd1,  OP_AUIPC = 4'd2,  OP_JAL   = 4'd3,
    OP_JALR   = 4'd4,  OP_BRANCH = 4'd5,  OP_LOAD  = 4'd6,  OP_STORE = 4'd7,
    OP_OPIMM  = 4'd8,  OP_OP     = 4'd9,  OP_FENCE = 4'd10, OP_SYSTEM = 4'd11
  } op_t;

  typedef struct packed {
    op_t         op;
    logic [31:0] imm;
    logic        we;
    logic        illegal;
  } dec_t;

  // Pure combinational decode of one instruction word.
  function automatic dec_t decode(input logic [31:0] instr);
    dec_t        d;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    f3    = instr[14:12];
    f7    = instr[31:25];
    imm_i = {{20{instr[31]}}, instr[31:20]};
    imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm_u = {instr[31:12], 12'h000};
    imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    d = '{op: OP_NONE, imm: 32'h0, we: 1'b0, illegal: 1'b0};
    case (instr[6:0])
      7'b0110111: begin d.op = OP_LUI;   d.imm = imm_u; d.we = 1'b1; end
      7'b0010111: begin d.op = OP_AUIPC; d.imm = imm_u; d.we = 1'b1; end
      7'b1101111: begin d.op = OP_JAL;   d.imm = imm_j; d.we = 1'b1; end
      7'b1100111: begin
        d.op = OP_JALR; d.imm = imm_i; d.we = 1'b1;
        d.illegal = (f3 != 3'b000);
      end
      7'b1100011: begin
        d.op = OP_BRANCH; d.imm = imm_b;
        d.illegal = (f3 == 3'b010) || (f3 == 3'b011);
      end
      7'b0000011: begin
        d.op = OP_LOAD; d.imm = imm_i; d.we = 1'b1;
        d.illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      7'b0100011: begin
        d.op = OP_STORE; d.imm = imm_s;
        d.illegal = (f3 > 3'b010);
      end
      7'b0010011: begin
        d.op = OP_OPIMM; d.imm = imm_i; d.we = 1'b1;
        if (f3 == 3'b001)      d.illegal = (f7 != 7'b0000000);
        else if (f3 == 3'b101) d.illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
      end
      7'b0110011: begin
        d.op = OP_OP; d.we = 1'b1;
        // Only SUB and SRA may use the alternate funct7.
        d.illegal = !((f7 == 7'b0000000) ||
                      ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      7'b0001111: begin
        d.op = OP_FENCE;
        d.illegal = !SUPPORT_FENCE;
      end
      7'b1110011: begin
        d.op = OP_SYSTEM; d.imm = imm_i;
        d.we = (f3 != 3'b000);
      end
      default: d.illegal = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) d.illegal = 1'b1;
    if (d.illegal) begin
      d.op  = OP_NONE;
      d.imm = 32'h0;
      d.we  = 1'b0;
    end
    if (instr[11:7] == 5'd0) d.we = 1'b0;
    return d;
  endfunction

  logic [31:0] pc_ff;
  logic        start_q;
  logic        start_edge;
  logic        transfer;
  dec_t        dec;

  assign rf_rs1_addr_o = fetch_instr_i[19:15];
  assign rf_rs2_addr_o = fetch_instr_i[24:20];
  assign fetch_ready_o = (~id_valid_o | id_ready_i) & ~flush_i;
  assign transfer      = fetch_valid_i & fetch_ready_o;
  assign start_edge    = start_i & ~start_q;
  assign dec           = decode(fetch_instr_i);

  // PC tracker, start edge detector and output valid; flush beats start beats transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_ff      <= RESET_PC;
      start_q    <= 1'b0;
      id_valid_o <= 1'b0;
    end else begin
      start_q <= start_i;
      if (flush_i) begin
        pc_ff      <= flush_addr_i & ~32'd3;
        id_valid_o <= 1'b0;
      end else if (start_edge) begin
        pc_ff      <= start_addr_i;
        id_valid_o <= 1'b0;
      end else if (transfer) begin
        pc_ff      <= pc_ff + 32'd4;
        id_valid_o <= 1'b1;
      end else if (id_ready_i) begin
        id_valid_o <= 1'b0;
      end
    end
  end

  // Decoded bundle register; only a real transfer updates it, so a stalled bundle holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_pc_o      <= 32'h0;
      id_instr_o   <= 32'h0;
      id_op_o      <= 4'h0;
      id_rd_o      <= 5'h0;
      id_rs1_o     <= 5'h0;
      id_rs2_o     <= 5'h0;
      id_funct3_o  <= 3'h0;
      id_f7b5_o    <= 1'b0;
      id_imm_o     <= 32'h0;
      id_we_o      <= 1'b0;
      id_illegal_o <= 1'b0;
    end else if (transfer && !start_edge) begin
      id_pc_o      <= pc_ff;
      id_instr_o   <= fetch_instr_i;
      id_op_o      <= dec.op;
      id_rd_o      <= fetch_instr_i[11:7];
      id_rs1_o     <= fetch_instr_i[19:15];
      id_rs2_o     <= fetch_instr_i[24:20];
      id_funct3_o  <= fetch_instr_i[14:12];
      id_f7b5_o    <= fetch_instr_i[30];
      id_imm_o     <= dec.imm;
      id_we_o      <= dec.we;
      id_illegal_o <= dec.illegal;
    end
  end

endmodule
